// File: rtl/mcs_io_ram_responder_if.sv
// MicroBlaze MCS IO bus signal bundle: the CPU side drives the strobes,
// address and write data, and the responder returns data and status.
interface mcs_io_ram_responder_if;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic        io_sel;
  logic        overrun;

  modport master (
    output io_addr_strobe, io_read_strobe, io_write_strobe,
           io_byte_enable, io_address, io_write_data,
    input  io_read_data, io_ready, io_sel, overrun
  );

  modport slave (
    input  io_addr_strobe, io_read_strobe, io_write_strobe,
           io_byte_enable, io_address, io_write_data,
    output io_read_data, io_ready, io_sel, overrun
  );
endinterface

// File: rtl/mcs_io_ram_responder.sv
// IO-bus responder: claims a fixed address window and serves it from a
// word-wide scratch RAM with byte write enables, answering each access with
// a one-cycle io_ready after WAIT wait states.
module mcs_io_ram_responder #(
  parameter logic [31:0] BASE   = 32'hc400_0000,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  mcs_io_ram_responder_if.slave bus
);

  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam logic [3:0]  LP_CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic              r_rd;
  logic [31:0]       r_rdata;
  logic              r_overrun;
  logic [31:0]       r_mem [DEPTH];

  logic              w_hit;
  logic              w_accept;
  logic              w_wr_q;
  logic              w_rd_q;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_load;
  logic              w_unused;

  assign w_hit    = (bus.io_address[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign w_accept = (r_state == ST_IDLE) && bus.io_addr_strobe && w_hit;
  assign w_unused = ^bus.io_address[1:0];

  // With WAIT=0 the RAM read happens on the strobe edge itself, so the
  // read index and qualifier come straight from the bus while idle.
  assign w_wr_q    = (r_state == ST_IDLE) ? bus.io_write_strobe : r_wr;
  assign w_rd_q    = (r_state == ST_IDLE) ? (bus.io_read_strobe & ~bus.io_write_strobe) : r_rd;
  assign w_rd_idx  = (r_state == ST_IDLE) ? bus.io_address[ADDR_W+1:2] : r_idx;
  assign w_rd_load = (w_state_nxt == ST_RESP) && (r_state != ST_RESP) && w_rd_q && !w_wr_q;

  assign bus.io_ready     = (r_state == ST_RESP);
  assign bus.io_sel       = (r_state != ST_IDLE);
  assign bus.io_read_data = r_rdata;
  assign bus.overrun      = r_overrun;

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter, request capture and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= bus.io_address[ADDR_W+1:2];
        r_be    <= bus.io_byte_enable;
        r_wdata <= bus.io_write_data;
        r_wr    <= bus.io_write_strobe;
        r_rd    <= bus.io_read_strobe & ~bus.io_write_strobe;
      end
      if (bus.io_addr_strobe && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Byte-lane RAM write on the edge that leaves RESP; reset aborts it.
  always_ff @(posedge clk) begin
    if (reset_n && (r_state == ST_RESP) && r_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port, loaded on the edge that enters RESP for reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (w_rd_load) begin
      r_rdata <= r_mem[w_rd_idx];
    end
  end

endmodule

// File: tb/tb_mcs_io_ram_responder.sv
// Bench for mcs_io_ram_responder: a WAIT=2 instance exercised from a vector
// table plus corner sequences, and a WAIT=0 instance hit with random
// back-to-back traffic against an array reference model.
module tb_mcs_io_ram_responder;

  localparam logic [31:0] BASE   = 32'hC400_0000;
  localparam int          WAIT_A = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mcs_io_ram_responder_if bus_a ();
  mcs_io_ram_responder_if bus_b ();

  mcs_io_ram_responder #(.BASE(BASE), .ADDR_W(10), .WAIT(WAIT_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  mcs_io_ram_responder #(.BASE(BASE), .ADDR_W(10), .WAIT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_a();
    bus_a.io_addr_strobe  = 1'b0;
    bus_a.io_read_strobe  = 1'b0;
    bus_a.io_write_strobe = 1'b0;
  endtask

  task automatic clear_b();
    bus_b.io_addr_strobe  = 1'b0;
    bus_b.io_read_strobe  = 1'b0;
    bus_b.io_write_strobe = 1'b0;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.io_addr_strobe  = 1'b1;
    bus_a.io_read_strobe  = v.rd;
    bus_a.io_write_strobe = v.wr;
    bus_a.io_byte_enable  = v.be;
    bus_a.io_address      = v.addr;
    bus_a.io_write_data   = v.wdata;
  endtask

  // One access on the WAIT=2 instance, observed for 20 cycles afterwards.
  task automatic access_a(input vec_t v, input string nm);
    int          ready_cnt = 0;
    int          ready_pos = 0;
    logic [31:0] sel_mask  = '0;
    logic [31:0] rd_at     = '0;
    logic [31:0] exp_sel;
    @(negedge clk);
    drive_a(v);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) clear_a();
      if (bus_a.io_ready) begin
        ready_cnt++;
        if (ready_pos == 0) ready_pos = k;
        rd_at = bus_a.io_read_data;
      end
      if (bus_a.io_sel) sel_mask[k] = 1'b1;
    end
    exp_sel = v.hit ? (((32'd1 << (WAIT_A + 1)) - 32'd1) << 1) : 32'd0;
    chk({nm, " ready_count"}, 32'(ready_cnt), v.hit ? 32'd1 : 32'd0);
    chk({nm, " sel_cycles"}, sel_mask, exp_sel);
    if (v.hit) begin
      chk({nm, " ready_latency"}, 32'(ready_pos), 32'(WAIT_A + 1));
      chk({nm, " read_data"}, rd_at, v.exp_rd);
    end
  endtask

  // One access on the WAIT=0 instance at full rate: strobe, then ready.
  task automatic access_b(input bit wr, input bit rd, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit chk_rd, input logic [31:0] exp_rd, input string nm);
    @(negedge clk);
    chk({nm, " idle_ready"}, 32'(bus_b.io_ready), 32'd0);
    bus_b.io_addr_strobe  = 1'b1;
    bus_b.io_read_strobe  = rd;
    bus_b.io_write_strobe = wr;
    bus_b.io_byte_enable  = be;
    bus_b.io_address      = addr;
    bus_b.io_write_data   = wdata;
    @(negedge clk);
    clear_b();
    chk({nm, " ready"}, 32'(bus_b.io_ready), 32'd1);
    chk({nm, " sel"}, 32'(bus_b.io_sel), 32'd1);
    if (chk_rd) chk({nm, " read_data"}, bus_b.io_read_data, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] model [1024];
    bit          written [1024];
    int          wq [$];
    vec_t        v;
    int          ready_cnt;

    tbl[0]  = '{1'b1, 1'b0, 4'hF, BASE + 32'h008,  32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, BASE + 32'h008,  32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b0, 4'h5, BASE + 32'h008,  32'h1122_3344, 1'b1, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, BASE + 32'h008,  32'h0,         1'b1, 32'hDE22_BE44};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, BASE + 32'h000,  32'h5566_7788, 1'b1, 32'hDE22_BE44};
    tbl[5]  = '{1'b0, 1'b1, 4'hF, BASE + 32'h000,  32'h0,         1'b1, 32'h5566_7788};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, BASE - 32'h004,  32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 4'hF, BASE + 32'h1000, 32'h0,         1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 4'hF, BASE + 32'hFFC,  32'h0BAD_CAFE, 1'b1, 32'h5566_7788};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, BASE + 32'hFFC,  32'h0,         1'b1, 32'h0BAD_CAFE};
    tbl[10] = '{1'b1, 1'b1, 4'hF, BASE + 32'h008,  32'hA5A5_A5A5, 1'b1, 32'h0BAD_CAFE};
    tbl[11] = '{1'b0, 1'b1, 4'hF, BASE + 32'h008,  32'h0,         1'b1, 32'hA5A5_A5A5};
    tbl[12] = '{1'b0, 1'b0, 4'hF, BASE + 32'h008,  32'h0,         1'b1, 32'hA5A5_A5A5};
    tbl[13] = '{1'b1, 1'b0, 4'h0, BASE + 32'h008,  32'hFFFF_FFFF, 1'b1, 32'hA5A5_A5A5};
    tbl[14] = '{1'b0, 1'b1, 4'hF, BASE + 32'h008,  32'h0,         1'b1, 32'hA5A5_A5A5};
    tbl[15] = '{1'b0, 1'b1, 4'hF, BASE + 32'h003,  32'h0,         1'b1, 32'h5566_7788};

    clear_a();
    clear_b();
    bus_a.io_byte_enable = '0; bus_a.io_address = '0; bus_a.io_write_data = '0;
    bus_b.io_byte_enable = '0; bus_b.io_address = '0; bus_b.io_write_data = '0;
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;

    // Reset values.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(bus_a.io_ready), 32'd0);
    chk("rst sel", 32'(bus_a.io_sel), 32'd0);
    chk("rst overrun", 32'(bus_a.overrun), 32'd0);
    chk("rst read_data", bus_a.io_read_data, 32'd0);
    chk("rst_b read_data", bus_b.io_read_data, 32'd0);
    reset_n = 1'b1;

    // Table-driven accesses on the WAIT=2 instance.
    for (int i = 0; i < 16; i++) begin
      access_a(tbl[i], $sformatf("vec%0d", i));
    end
    chk("table overrun", 32'(bus_a.overrun), 32'd0);

    // Second hit strobe one cycle after the first: ignored, overrun set.
    @(negedge clk);
    v = '{1'b1, 1'b0, 4'hF, BASE + 32'h010, 32'hCAFE_F00D, 1'b1, 32'h0};
    drive_a(v);
    ready_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus_a.io_write_data = 32'h1234_5678;
      if (k == 2) clear_a();
      if (bus_a.io_ready) ready_cnt++;
    end
    chk("ovr ready_count", 32'(ready_cnt), 32'd1);
    chk("ovr flag", 32'(bus_a.overrun), 32'd1);
    access_a('{1'b0, 1'b1, 4'hF, BASE + 32'h010, 32'h0, 1'b1, 32'hCAFE_F00D}, "ovr readback");
    chk("ovr sticky", 32'(bus_a.overrun), 32'd1);

    // Reset during the wait phase of a write aborts it.
    @(negedge clk);
    drive_a('{1'b1, 1'b0, 4'hF, BASE, 32'h0000_00AA, 1'b1, 32'h0});
    @(negedge clk);
    clear_a();
    chk("abort sel_before", 32'(bus_a.io_sel), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(bus_a.io_ready), 32'd0);
    chk("abort sel", 32'(bus_a.io_sel), 32'd0);
    chk("abort overrun", 32'(bus_a.overrun), 32'd0);
    chk("abort read_data", bus_a.io_read_data, 32'd0);
    reset_n = 1'b1;
    ready_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_a.io_ready) ready_cnt++;
    end
    chk("abort no_ready", 32'(ready_cnt), 32'd0);
    access_a('{1'b0, 1'b1, 4'hF, BASE, 32'h0, 1'b1, 32'h5566_7788}, "abort readback");

    // Random write/read pairs at full rate on the WAIT=0 instance.
    for (int it = 0; it < 64; it++) begin
      int          idx;
      int          ridx;
      logic [3:0]  be;
      logic [31:0] d;
      logic [31:0] a;
      idx = int'($urandom_range(0, 1023));
      be  = written[idx] ? 4'($urandom_range(0, 15)) : 4'hF;
      d   = $urandom;
      a   = BASE + 32'(idx) * 32'd4 + 32'($urandom_range(0, 3));
      access_b(1'b1, 1'b0, be, a, d, 1'b0, 32'h0, $sformatf("rnd%0d wr", it));
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[idx] = (model[idx] & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
      end
      if (!written[idx]) wq.push_back(idx);
      written[idx] = 1'b1;
      ridx = wq[$urandom_range(0, wq.size() - 1)];
      a    = BASE + 32'(ridx) * 32'd4;
      access_b(1'b0, 1'b1, 4'hF, a, 32'h0, 1'b1, model[ridx], $sformatf("rnd%0d rd", it));
    end
    @(negedge clk);
    chk("rnd overrun", 32'(bus_b.overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
